i2c_cmd_arbiter: RTL

I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

---
 rtl/i2c_arb_pkg.sv | 12 +
 rtl/i2c_cmd_arbiter_rr_priority_pick.sv | 30 +++
 rtl/i2c_cmd_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C command arbiter: FSM state encoding and arbitration mode names.
package i2c_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam string MODE_RR    = "RR";
  localparam string MODE_FIXED = "FIXED";

endpackage

// File: rtl/i2c_cmd_arbiter_rr_priority_pick.sv
// Combinational circular priority pick: first asserted request at or after start, wrapping.
// Zero latency; purely combinational, no backpressure.
module rr_priority_pick #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(start) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Arbitrates NPORT requesters onto one I2C master command port; grant registered one cycle after request.
// Owner's command beat passes through combinationally; m_ready backpressures only the owner.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int    NPORT   = 8,
  parameter int    CSIZE   = 4,
  parameter int    DSIZE   = 8,
  parameter string MODE    = "RR",
  parameter int    TIMEOUT = 65535,
  localparam int   IW      = $clog2(NPORT)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NPORT-1:0]       s_req,
  output logic [NPORT-1:0]       s_grant,
  input  logic [NPORT-1:0]       s_release,
  input  logic [NPORT-1:0]       s_valid,
  output logic [NPORT-1:0]       s_ready,
  input  logic [NPORT*CSIZE-1:0] s_cmd,
  input  logic [NPORT*DSIZE-1:0] s_data,
  output logic [NPORT-1:0]       s_rd_valid,
  output logic [DSIZE-1:0]       s_rd_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [CSIZE-1:0]       m_cmd,
  output logic [DSIZE-1:0]       m_data,
  input  logic                   m_rd_valid,
  input  logic [DSIZE-1:0]       m_rd_data,
  output logic [IW-1:0]          owner_id,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int WW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit FIXED_MODE = (MODE == MODE_FIXED);

  arb_state_t       state;
  logic [NPORT-1:0] grant_q;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    ptr;
  logic [WW-1:0]    wd_cnt;
  logic             timeout_q;

  logic [NPORT-1:0] win_oh;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic [IW-1:0]    start_ptr;

  logic own_act;
  logic beat;
  logic rel;
  logic wd_fire;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == IW'(NPORT - 1)) ? '0 : i + 1'b1;
  endfunction

  assign start_ptr = FIXED_MODE ? '0 : ptr;

  rr_priority_pick #(.N(NPORT)) u_pick (
    .req   (s_req),
    .start (start_ptr),
    .grant (win_oh),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Gating with rst keeps a beat from slipping out in the cycle reset is applied.
  assign own_act = (state == OWN) && !rst;
  assign beat    = own_act && s_valid[owner] && m_ready;
  assign rel     = s_release[owner];
  assign wd_fire = (TIMEOUT != 0) && !beat && (wd_cnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      grant_q   <= '0;
      owner     <= '0;
      ptr       <= '0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            state   <= OWN;
            grant_q <= win_oh;
            owner   <= win_idx;
            ptr     <= wrap_inc(win_idx);
            wd_cnt  <= '0;
          end
        end
        OWN: begin
          // A release arriving with watchdog expiry wins: no error pulse.
          if (rel) begin
            state   <= IDLE;
            grant_q <= '0;
            wd_cnt  <= '0;
          end else if (wd_fire) begin
            state     <= IDLE;
            grant_q   <= '0;
            wd_cnt    <= '0;
            ptr       <= wrap_inc(owner);
            timeout_q <= 1'b1;
          end else if (beat) begin
            wd_cnt <= '0;
          end else if (TIMEOUT != 0) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready    = '0;
    s_rd_valid = '0;
    m_valid    = 1'b0;
    if (own_act) begin
      s_ready[owner]    = m_ready;
      s_rd_valid[owner] = m_rd_valid;
      m_valid           = s_valid[owner];
    end
  end

  assign m_cmd       = s_cmd[int'(owner)*CSIZE +: CSIZE];
  assign m_data      = s_data[int'(owner)*DSIZE +: DSIZE];
  assign s_rd_data   = m_rd_data;
  assign s_grant     = grant_q;
  assign owner_id    = owner;
  assign busy        = (state == OWN);
  assign timeout_err = timeout_q;

endmodule
